whac_game_ctrl: RTL and testbench

WHAC_GAME_CTRL -- requirements
Module: whac_game_ctrl

---
 rtl/whac_game_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_whac_game_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/whac_game_ctrl.sv
// Whack-a-mole game controller: mole spawning, lifetime timeout, scoring and lives.
// Defining WHAC_STREAK_BONUS_EN enables streak-based bonus points per hit.
module whac_game_ctrl #(
    parameter int NUM_MOLES       = 18,
    parameter int CLKS_PER_MS     = 50000,
    parameter int BASE_TIMEOUT_MS = 1600,
    parameter int MAX_LIVES       = 3,
    parameter int SCORE_W         = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [1:0]                     level,
    input  logic [NUM_MOLES-1:0]           toggle_switches,
    input  logic [15:0]                    random_value,
    output logic [NUM_MOLES-1:0]           leds,
    output logic [SCORE_W-1:0]             points,
    output logic [$clog2(MAX_LIVES+1)-1:0] lives,
    output logic                           game_over,
    output logic                           hit_pulse
);
    localparam int IW     = (NUM_MOLES > 1) ? $clog2(NUM_MOLES) : 1;
    localparam int LW     = $clog2(MAX_LIVES + 1);
    localparam int CW     = $clog2(CLKS_PER_MS + 1);
    localparam int TW     = $clog2(BASE_TIMEOUT_MS + 1);
    localparam int GW     = 9;
    localparam int GAP_MS = 250;

    typedef enum logic [2:0] {IDLE, SPAWN, ACTIVE, GAP, GAME_OVER} state_e;

    state_e                 state_q, state_d;
    logic [NUM_MOLES-1:0]   leds_q, leds_d;
    logic [SCORE_W-1:0]     points_q, points_d;
    logic [LW-1:0]          lives_q, lives_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [TW-1:0]          timeout_q, timeout_d;
    logic [GW-1:0]          gap_q, gap_d, gap_load;
    logic [CW-1:0]          ms_cnt_q, ms_cnt_d;
    logic                   hit_q, hit_d;
    logic [NUM_MOLES-1:0]   sw_prev_q;
    logic [NUM_MOLES-1:0]   sw_edges;
    logic                   ms_tick, hit, expire, miss;
    logic [2:0]             inc;

    // Never returns the previous index so the same mole cannot light twice in a row.
    function automatic logic [IW-1:0] pick_index(input logic [15:0] rnd, input logic [IW-1:0] prev);
        logic [15:0] m;
        m = rnd % 16'(NUM_MOLES);
        if (m == {{(16-IW){1'b0}}, prev}) begin
            m = (m + 16'd1) % 16'(NUM_MOLES);
        end
        return IW'(m);
    endfunction

    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a, input logic [2:0] b);
        logic [SCORE_W:0] sum;
        sum = {1'b0, a} + (SCORE_W+1)'(b);
        return sum[SCORE_W] ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
    endfunction

    assign ms_tick  = (ms_cnt_q == CW'(CLKS_PER_MS - 1));
    assign sw_edges = toggle_switches ^ sw_prev_q;
    assign hit      = (state_q == ACTIVE) && |(sw_edges & leds_q);
    assign expire   = (state_q == ACTIVE) && ms_tick && (timeout_q <= TW'(1));
    assign miss     = expire && !hit;
    assign gap_load = GW'(GAP_MS) + ((level == 2'd3) ? GW'(random_value[7:0]) : GW'(0));

`ifdef WHAC_STREAK_BONUS_EN
    logic [3:0] streak_q, streak_d;

    // streak/4 is already capped at 3 by the 4-bit saturating counter.
    assign inc = 3'd1 + {1'b0, streak_q[3:2]};

    always_comb begin
        streak_d = streak_q;
        if (start || miss) begin
            streak_d = '0;
        end else if (hit && streak_q != 4'hF) begin
            streak_d = streak_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end
`else
    assign inc = 3'd1;
`endif

    always_comb begin
        ms_cnt_d = ms_cnt_q + CW'(1);
        if (state_d == SPAWN || ms_tick) begin
            ms_cnt_d = '0;
        end
    end

    always_comb begin
        state_d   = state_q;
        leds_d    = leds_q;
        points_d  = points_q;
        lives_d   = lives_q;
        idx_d     = idx_q;
        timeout_d = timeout_q;
        gap_d     = gap_q;
        hit_d     = 1'b0;
        if (start) begin
            points_d = '0;
            lives_d  = LW'(MAX_LIVES);
            leds_d   = '0;
            state_d  = SPAWN;
        end else begin
            case (state_q)
                SPAWN: begin
                    idx_d     = pick_index(random_value, idx_q);
                    leds_d    = {{(NUM_MOLES-1){1'b0}}, 1'b1} << idx_d;
                    timeout_d = TW'(BASE_TIMEOUT_MS) >> level;
                    state_d   = ACTIVE;
                end
                ACTIVE: begin
                    // A hit in the expiry cycle still counts as a hit.
                    if (hit) begin
                        points_d = sat_add(points_q, inc);
                        hit_d    = 1'b1;
                        leds_d   = '0;
                        gap_d    = gap_load;
                        state_d  = GAP;
                    end else if (expire) begin
                        lives_d = lives_q - LW'(1);
                        leds_d  = '0;
                        if (lives_q == LW'(1)) begin
                            state_d = GAME_OVER;
                        end else begin
                            gap_d   = gap_load;
                            state_d = GAP;
                        end
                    end else if (ms_tick) begin
                        timeout_d = timeout_q - TW'(1);
                    end
                end
                GAP: begin
                    if (ms_tick) begin
                        if (gap_q <= GW'(1)) begin
                            state_d = SPAWN;
                        end else begin
                            gap_d = gap_q - GW'(1);
                        end
                    end
                end
                IDLE, GAME_OVER: begin
                    state_d = state_q;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            leds_q    <= '0;
            points_q  <= '0;
            lives_q   <= LW'(MAX_LIVES);
            idx_q     <= '0;
            timeout_q <= '0;
            gap_q     <= '0;
            ms_cnt_q  <= '0;
            hit_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            leds_q    <= leds_d;
            points_q  <= points_d;
            lives_q   <= lives_d;
            idx_q     <= idx_d;
            timeout_q <= timeout_d;
            gap_q     <= gap_d;
            ms_cnt_q  <= ms_cnt_d;
            hit_q     <= hit_d;
        end
    end

    // Edge-detect history tracks the switches continuously so no stale edge survives a state change.
    always_ff @(posedge clk) begin
        sw_prev_q <= toggle_switches;
    end

    assign leds      = leds_q;
    assign points    = points_q;
    assign lives     = lives_q;
    assign game_over = (state_q == GAME_OVER);
    assign hit_pulse = hit_q;
endmodule

// File: tb/tb_whac_game_ctrl.sv
// Directed self-checking bench for whac_game_ctrl (2 clk per ms tick, 4-bit score).
module tb_whac_game_ctrl;
    localparam int N = 18;

`ifdef WHAC_STREAK_BONUS_EN
    localparam int EXP_AFTER8    = 12;
    localparam int EXP_AFTERMISS = 13;
`else
    localparam int EXP_AFTER8    = 8;
    localparam int EXP_AFTERMISS = 9;
`endif

    logic         clk = 1'b0;
    logic         reset, start;
    logic [1:0]   level;
    logic [N-1:0] sw;
    logic [15:0]  rnd;
    logic [N-1:0] leds;
    logic [3:0]   points;
    logic [1:0]   lives;
    logic         game_over, hit_pulse;

    int n_checks = 0;
    int n_errors = 0;
    int exp_pts  = 0;
    int streak   = 0;
    int prev_idx = 0;
    int cur_idx  = 0;

    always #5 clk = ~clk;

    whac_game_ctrl #(
        .NUM_MOLES(N), .CLKS_PER_MS(2), .BASE_TIMEOUT_MS(1600), .MAX_LIVES(3), .SCORE_W(4)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .level(level),
        .toggle_switches(sw), .random_value(rnd),
        .leds(leds), .points(points), .lives(lives),
        .game_over(game_over), .hit_pulse(hit_pulse)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic int exp_index(input int r, input int prev);
        int m;
        m = r % N;
        if (m == prev) m = (m + 1) % N;
        return m;
    endfunction

    // Waits for a mole to light and checks it is the expected one.
    task automatic wait_mole(input int r, input int bound);
        int k;
        bit seen;
        seen = 1'b0;
        for (k = 0; k < bound; k++) begin
            tick(1);
            if (leds != '0) begin
                seen = 1'b1;
                break;
            end
        end
        check("spawn_seen", 32'(seen), 32'd1);
        cur_idx = exp_index(r, prev_idx);
        prev_idx = cur_idx;
        check("spawn_idx", 32'(leds), 32'd1 << cur_idx);
    endtask

    task automatic do_hit(input int r);
        int inc;
        rnd = r[15:0];
        wait_mole(r, 600);
        sw[cur_idx] = ~sw[cur_idx];
        tick(1);
`ifdef WHAC_STREAK_BONUS_EN
        inc = 1 + ((streak / 4 > 3) ? 3 : streak / 4);
        streak++;
`else
        inc = 1;
`endif
        exp_pts = (exp_pts + inc > 15) ? 15 : exp_pts + inc;
        check("hit_pulse", 32'(hit_pulse), 32'd1);
        check("hit_points", 32'(points), 32'(exp_pts));
        check("hit_leds", 32'(leds), 32'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; level = 2'd0; sw = '0; rnd = 16'd5;
        tick(3);
        check("rst_leds", 32'(leds), 32'd0);
        check("rst_points", 32'(points), 32'd0);
        check("rst_lives", 32'(lives), 32'd3);
        check("rst_game_over", 32'(game_over), 32'd0);
        check("rst_hit_pulse", 32'(hit_pulse), 32'd0);
        reset = 1'b0;
        tick(2);
        check("idle_leds", 32'(leds), 32'd0);

        // Start: mole 5 lights two edges later.
        start = 1'b1;
        tick(1);
        start = 1'b0;
        check("spawn_cycle_leds", 32'(leds), 32'd0);
        tick(1);
        check("start_leds", 32'(leds), 32'd1 << 5);
        check("start_lives", 32'(lives), 32'd3);
        check("start_points", 32'(points), 32'd0);
        prev_idx = 5;

        // Wrong switch is ignored.
        sw[3] = ~sw[3];
        tick(2);
        check("wrong_sw_points", 32'(points), 32'd0);
        check("wrong_sw_leds", 32'(leds), 32'd1 << 5);
        check("wrong_sw_lives", 32'(lives), 32'd3);

        // Hit on mole 5.
        sw[5] = ~sw[5];
        tick(1);
        check("hit5_pulse", 32'(hit_pulse), 32'd1);
        check("hit5_points", 32'(points), 32'd1);
        check("hit5_leds", 32'(leds), 32'd0);
        level = 2'd2;
        tick(1);
        check("hit5_pulse_end", 32'(hit_pulse), 32'd0);
        tick(493);
        check("gap_leds", 32'(leds), 32'd0);
        wait_mole(5, 30);
        check("no_repeat_6", 32'(leds), 32'd1 << 6);

        // Level 2 miss: 400 ticks = 799 edges after the mole lights.
        tick(798);
        check("pre_miss_lives", 32'(lives), 32'd3);
        check("pre_miss_leds", 32'(leds), 32'd1 << 6);
        tick(1);
        check("miss_lives", 32'(lives), 32'd2);
        check("miss_leds", 32'(leds), 32'd0);
        check("miss_game_over", 32'(game_over), 32'd0);

        // Hit arriving in the expiry cycle wins.
        wait_mole(5, 600);
        tick(798);
        sw[5] = ~sw[5];
        tick(1);
        check("tie_pulse", 32'(hit_pulse), 32'd1);
        check("tie_lives", 32'(lives), 32'd2);
        check("tie_points", 32'(points), 32'd2);

        // Two more misses end the game.
        wait_mole(5, 600);
        tick(799);
        check("miss2_lives", 32'(lives), 32'd1);
        wait_mole(5, 600);
        tick(799);
        check("over_lives", 32'(lives), 32'd0);
        check("over_flag", 32'(game_over), 32'd1);
        check("over_leds", 32'(leds), 32'd0);
        sw[5] = ~sw[5];
        tick(20);
        check("frozen_points", 32'(points), 32'd2);
        check("frozen_lives", 32'(lives), 32'd0);
        check("frozen_leds", 32'(leds), 32'd0);
        check("frozen_flag", 32'(game_over), 32'd1);

        // Restart, streak of 8, a miss, then saturation at 15.
        rnd = 16'd1;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        check("restart_points", 32'(points), 32'd0);
        check("restart_lives", 32'(lives), 32'd3);
        check("restart_flag", 32'(game_over), 32'd0);
        exp_pts = 0;
        streak = 0;
        for (int i = 0; i < 8; i++) do_hit(i * 7 + 1);
        check("after8_points", 32'(points), 32'(EXP_AFTER8));
        rnd = 16'd100;
        wait_mole(100, 600);
        tick(799);
        check("streak_miss_lives", 32'(lives), 32'd2);
        streak = 0;
        do_hit(3);
        check("after_miss_points", 32'(points), 32'(EXP_AFTERMISS));
        for (int i = 1; i < 9; i++) do_hit(i * 11 + 3);
        check("saturated_points", 32'(points), 32'd15);

        // Reset beats start and a hit in the same cycle.
        rnd = 16'd2;
        wait_mole(2, 600);
        reset = 1'b1;
        start = 1'b1;
        sw[cur_idx] = ~sw[cur_idx];
        tick(1);
        reset = 1'b0;
        start = 1'b0;
        check("rst_mid_leds", 32'(leds), 32'd0);
        check("rst_mid_points", 32'(points), 32'd0);
        check("rst_mid_lives", 32'(lives), 32'd3);
        check("rst_mid_pulse", 32'(hit_pulse), 32'd0);
        tick(5);
        check("rst_mid_idle_leds", 32'(leds), 32'd0);
        check("rst_mid_idle_flag", 32'(game_over), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
